gshare_predictor: RTL and testbench
===================================

Name: gshare_predictor

Overview:
Parametrised successor to the 2-bit direction predictor. Adds global-history (gshare) indexing, configurable table depth, history length and counter width, speculative history update at fetch, and history repair on mispredict. Sits between IF (query) and RoB (resolve/update). Also keeps saturating statistics counters for performance debug.

Parameters:
INDEX_WIDTH, 6, log2 of pattern-table entries (SIZE = 1 << INDEX_WIDTH).
HIST_WIDTH, 6, global history register (GHR) length in bits; legal range 1..INDEX_WIDTH.
CNT_WIDTH, 2, saturating counter width; legal range 1..4.
STAT_WIDTH, 32, width of statistics counters.

Ports:
clk_in  input  1  clock, rising edge.
rst_n_in  input  1  asynchronous reset, active low.
rdy_in  input  1  global ready; low = pause, all state frozen.
query_PC  input  32  fetch PC of the branch being predicted.
query_en  input  1  IF commits this prediction; shifts GHR speculatively.
result_out  output  1  predicted direction (1 = taken), combinational.
query_ghr_out  output  HIST_WIDTH  current GHR; IF carries it with the instruction to RoB.
update_en  input  1  RoB resolves a conditional branch.
update_PC  input  32  PC of the resolved branch.
update_ghr  input  HIST_WIDTH  GHR snapshot captured when that branch was predicted.
update_result  input  1  actual direction (1 = taken).
update_mispredict  input  1  actual direction differs from prediction; qualified by update_en.
stat_total_out  output  STAT_WIDTH  resolved branch count.
stat_miss_out  output  STAT_WIDTH  mispredict count.

Behaviour:
- Index: idx(PC, h) = PC[INDEX_WIDTH+1:2] XOR zero-extend(h) to INDEX_WIDTH. PC bits [1:0] ignored.
- Query: result_out = MSB of counter[idx(query_PC, GHR)]. query_ghr_out = GHR. Both purely combinational from current registered state. No bypass of a same-cycle update.
- Counter update when update_en && rdy_in:
  - Slot is idx(update_PC, update_ghr).
  - Taken: +1, saturating at 2^CNT_WIDTH-1.
  - Not taken: -1, saturating at 0.
  - Only that slot changes.
- GHR next-state when rdy_in, in priority order:
  1. update_en && update_mispredict: GHR <= {update_ghr[HIST_WIDTH-2:0], update_result}. This repairs history and wins over any same-cycle query_en.
  2. Else query_en: GHR <= {GHR[HIST_WIDTH-2:0], result_out}.
  3. Else hold.
  - HIST_WIDTH = 1: GHR is replaced by the new bit alone.
- Simultaneous query and update to the same slot: query returns the pre-update value; the new value is visible the next cycle.
- Statistics, when update_en && rdy_in:
  - stat_total_out increments.
  - stat_miss_out increments if update_mispredict.
  - Both saturate at all-ones (no wrap).
- rdy_in low: no table, GHR or stat changes. result_out still reflects held state.
- Reset, asynchronous on rst_n_in low, takes effect immediately regardless of clk_in and rdy_in:
  - Every counter = 2^(CNT_WIDTH-1) (weakly taken; 2'b10 at default).
  - GHR = 0, both stats = 0.
  - Therefore result_out = 1 and query_ghr_out = 0 during and after reset.
  - Deassertion is synchronised externally. First update can land on the first rising edge after rst_n_in is high.
- Reset mid-operation: any in-flight update in that cycle is discarded; no partial writes.
- Stat and table updates never depend on query_en.

Test Plan:
- Reset: pulse rst_n_in low between edges, default params -> result_out=1 immediately for any PC, query_ghr_out=0, stats=0.
- Saturation (HIST_WIDTH=1, GHR=0), PC 0x40:
  - 3 updates taken -> counter 3, result_out=1.
  - Then 4 not-taken updates -> counter 0, result_out=0.
  - Then 1 taken -> counter 1, result_out still 0.
- Speculative history: query_en for 3 cycles with prediction 1 -> GHR 0b000111.
- History-indexed aliasing: update PC 0x40 with update_ghr=0b000001, not taken twice -> idx 0x11 counter 0.
  - Query PC 0x44 with GHR=0b000000 -> idx 0x11, result_out=0.
  - Query PC 0x40 with GHR=0 -> idx 0x10, result_out=1.
- Mispredict repair priority: GHR=0b101010; same cycle query_en=1 and update_en=1, update_mispredict=1, update_ghr=0b000011, update_result=0 -> GHR=0b000110 next cycle; stat_miss_out +1, stat_total_out +1.
- Pause: rdy_in=0 with update_en and query_en held high 5 cycles -> table, GHR and stats unchanged. Raise rdy_in -> exactly one update applied per subsequent cycle.

Source files
------------

// File: rtl/gshare_predictor_if.sv
// Query/resolve/statistics bundle between IF, RoB and the gshare direction predictor.
interface gshare_predictor_if #(
    parameter int unsigned HIST_WIDTH = 6,
    parameter int unsigned STAT_WIDTH = 32
);
    logic [31:0]            query_PC;
    logic                   query_en;
    logic                   result_out;
    logic [HIST_WIDTH-1:0]  query_ghr_out;
    logic                   update_en;
    logic [31:0]            update_PC;
    logic [HIST_WIDTH-1:0]  update_ghr;
    logic                   update_result;
    logic                   update_mispredict;
    logic [STAT_WIDTH-1:0]  stat_total_out;
    logic [STAT_WIDTH-1:0]  stat_miss_out;

    // Pipeline side: issues queries and resolutions, observes prediction and stats.
    modport master (
        output query_PC, query_en,
        output update_en, update_PC, update_ghr, update_result, update_mispredict,
        input  result_out, query_ghr_out, stat_total_out, stat_miss_out
    );

    // Predictor side.
    modport slave (
        input  query_PC, query_en,
        input  update_en, update_PC, update_ghr, update_result, update_mispredict,
        output result_out, query_ghr_out, stat_total_out, stat_miss_out
    );
endinterface

// File: rtl/gshare_predictor.sv
// Gshare branch direction predictor: PC xor global history indexes a table of
// saturating counters; history is shifted speculatively at fetch and repaired
// from the RoB snapshot on a mispredict.
module gshare_predictor #(
    parameter int unsigned INDEX_WIDTH = 6,
    parameter int unsigned HIST_WIDTH  = 6,
    parameter int unsigned CNT_WIDTH   = 2,
    parameter int unsigned STAT_WIDTH  = 32
) (
    input  logic                 clk_in,
    input  logic                 rst_n_in,
    input  logic                 rdy_in,
    gshare_predictor_if.slave    bus
);
    localparam int unsigned SIZE = 1 << INDEX_WIDTH;
    localparam logic [CNT_WIDTH-1:0] CNT_MAX  = '1;
    localparam logic [CNT_WIDTH-1:0] CNT_INIT = CNT_WIDTH'(1) << (CNT_WIDTH - 1);

    logic [CNT_WIDTH-1:0]   cnt_tbl [SIZE];
    logic [HIST_WIDTH-1:0]  ghr;
    logic [HIST_WIDTH-1:0]  ghr_next;
    logic [INDEX_WIDTH-1:0] q_idx;
    logic [INDEX_WIDTH-1:0] u_idx;
    logic [CNT_WIDTH-1:0]   u_cnt;
    logic [CNT_WIDTH-1:0]   u_cnt_next;
    logic [STAT_WIDTH-1:0]  stat_total;
    logic [STAT_WIDTH-1:0]  stat_miss;
    logic                   pred;
    logic                   upd_go;

    // Word-aligned PC bits folded with zero-extended history.
    function automatic logic [INDEX_WIDTH-1:0] slot_idx(input logic [31:0] pc,
                                                        input logic [HIST_WIDTH-1:0] h);
        return pc[INDEX_WIDTH+1:2] ^ INDEX_WIDTH'(h);
    endfunction

    // Byte offset and high PC bits never reach the index.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{bus.query_PC[31:INDEX_WIDTH+2], bus.query_PC[1:0],
                              bus.update_PC[31:INDEX_WIDTH+2], bus.update_PC[1:0]};

    assign q_idx  = slot_idx(bus.query_PC, ghr);
    assign u_idx  = slot_idx(bus.update_PC, bus.update_ghr);
    assign u_cnt  = cnt_tbl[u_idx];
    assign pred   = cnt_tbl[q_idx][CNT_WIDTH-1];
    assign upd_go = rdy_in && bus.update_en;

    assign bus.result_out     = pred;
    assign bus.query_ghr_out  = ghr;
    assign bus.stat_total_out = stat_total;
    assign bus.stat_miss_out  = stat_miss;

    // Saturating step of the resolved slot's counter.
    always_comb begin
        u_cnt_next = u_cnt;
        if (bus.update_result) begin
            if (u_cnt != CNT_MAX) u_cnt_next = u_cnt + CNT_WIDTH'(1);
        end else begin
            if (u_cnt != '0) u_cnt_next = u_cnt - CNT_WIDTH'(1);
        end
    end

    // History next-state: mispredict repair outranks the speculative shift.
    always_comb begin
        ghr_next = ghr;
        if (bus.update_en && bus.update_mispredict)
            ghr_next = HIST_WIDTH'({bus.update_ghr, bus.update_result});
        else if (bus.query_en)
            ghr_next = HIST_WIDTH'({ghr, pred});
    end

    // Pattern table: weakly-taken at reset, one slot written per resolve.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            for (int unsigned i = 0; i < SIZE; i++) cnt_tbl[i] <= CNT_INIT;
        end else if (upd_go) begin
            cnt_tbl[u_idx] <= u_cnt_next;
        end
    end

    // Global history register.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) ghr <= '0;
        else if (rdy_in) ghr <= ghr_next;
    end

    // Saturating resolve/mispredict statistics.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            stat_total <= '0;
            stat_miss  <= '0;
        end else if (upd_go) begin
            if (stat_total != '1) stat_total <= stat_total + STAT_WIDTH'(1);
            if (bus.update_mispredict && (stat_miss != '1)) stat_miss <= stat_miss + STAT_WIDTH'(1);
        end
    end
endmodule

// File: tb/tb_gshare_predictor.sv
// Directed table-driven bench for gshare_predictor: a default instance and a
// narrow instance (1-bit history, 1-bit counters, 2-bit stats) for boundaries.
module tb_gshare_predictor;
    logic clk_in = 1'b0;
    logic rst_n  = 1'b1;
    logic rdy0   = 1'b1;
    logic rdy1   = 1'b1;

    always #5 clk_in = ~clk_in;

    gshare_predictor_if #(.HIST_WIDTH(6), .STAT_WIDTH(32)) b0 ();
    gshare_predictor_if #(.HIST_WIDTH(1), .STAT_WIDTH(2))  b1 ();

    gshare_predictor #(.INDEX_WIDTH(6), .HIST_WIDTH(6), .CNT_WIDTH(2), .STAT_WIDTH(32)) dut0 (
        .clk_in(clk_in), .rst_n_in(rst_n), .rdy_in(rdy0), .bus(b0.slave));
    gshare_predictor #(.INDEX_WIDTH(4), .HIST_WIDTH(1), .CNT_WIDTH(1), .STAT_WIDTH(2)) dut1 (
        .clk_in(clk_in), .rst_n_in(rst_n), .rdy_in(rdy1), .bus(b1.slave));

    typedef struct {
        logic        rdy;
        logic        q_en;
        logic [31:0] q_pc;
        logic        u_en;
        logic [31:0] u_pc;
        logic [5:0]  u_ghr;
        logic        u_res;
        logic        u_misp;
        logic        e_res;
        logic [31:0] e_ghr;
        logic [31:0] e_tot;
        logic [31:0] e_miss;
    } vec_t;

    int n_cmp = 0;
    int n_bad = 0;
    vec_t tv0[$];
    vec_t tv1[$];

    function automatic vec_t mk(input logic rdy, input logic q_en, input logic [31:0] q_pc,
                                input logic u_en, input logic [31:0] u_pc, input logic [5:0] u_ghr,
                                input logic u_res, input logic u_misp, input logic e_res,
                                input logic [31:0] e_ghr, input logic [31:0] e_tot,
                                input logic [31:0] e_miss);
        vec_t v;
        v.rdy = rdy; v.q_en = q_en; v.q_pc = q_pc; v.u_en = u_en; v.u_pc = u_pc;
        v.u_ghr = u_ghr; v.u_res = u_res; v.u_misp = u_misp; v.e_res = e_res;
        v.e_ghr = e_ghr; v.e_tot = e_tot; v.e_miss = e_miss;
        return v;
    endfunction

    task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s[%0d]: got 0x%0h expected 0x%0h", nm, idx, act, exp);
        end
    endtask

    task automatic drive(input int which, input vec_t v);
        if (which == 0) begin
            rdy0 = v.rdy; b0.query_en = v.q_en; b0.query_PC = v.q_pc;
            b0.update_en = v.u_en; b0.update_PC = v.u_pc; b0.update_ghr = v.u_ghr;
            b0.update_result = v.u_res; b0.update_mispredict = v.u_misp;
        end else begin
            rdy1 = v.rdy; b1.query_en = v.q_en; b1.query_PC = v.q_pc;
            b1.update_en = v.u_en; b1.update_PC = v.u_pc; b1.update_ghr = v.u_ghr[0];
            b1.update_result = v.u_res; b1.update_mispredict = v.u_misp;
        end
    endtask

    task automatic check_outs(input int which, input string tag, input int i, input vec_t v);
        if (which == 0) begin
            chk({tag, ".result"}, i, 32'(b0.result_out), 32'(v.e_res));
            chk({tag, ".ghr"},    i, 32'(b0.query_ghr_out), v.e_ghr);
            chk({tag, ".total"},  i, b0.stat_total_out, v.e_tot);
            chk({tag, ".miss"},   i, b0.stat_miss_out, v.e_miss);
        end else begin
            chk({tag, ".result"}, i, 32'(b1.result_out), 32'(v.e_res));
            chk({tag, ".ghr"},    i, 32'(b1.query_ghr_out), v.e_ghr);
            chk({tag, ".total"},  i, 32'(b1.stat_total_out), v.e_tot);
            chk({tag, ".miss"},   i, 32'(b1.stat_miss_out), v.e_miss);
        end
    endtask

    // Drive between edges, let one rising edge pass, sample 1ns later.
    task automatic apply(input int which, input string tag, input int i, input vec_t v);
        @(negedge clk_in);
        drive(which, v);
        @(posedge clk_in);
        #1;
        check_outs(which, tag, i, v);
    endtask

    vec_t idle;

    initial begin
        idle = mk(1, 0, 32'h0, 0, 32'h0, 6'h0, 0, 0, 1, 0, 0, 0);
        drive(0, idle);
        drive(1, idle);

        // Default instance: aliasing through history, then saturation on slot 0x10.
        tv0.push_back(mk(1, 0, 32'h44, 1, 32'h40, 6'h01, 0, 0, 0, 32'h00, 1, 0));
        tv0.push_back(mk(1, 0, 32'h44, 1, 32'h40, 6'h01, 0, 0, 0, 32'h00, 2, 0));
        tv0.push_back(mk(1, 0, 32'h44, 0, 32'h0,  6'h00, 0, 0, 0, 32'h00, 2, 0));
        tv0.push_back(mk(1, 0, 32'h40, 0, 32'h0,  6'h00, 0, 0, 1, 32'h00, 2, 0));
        tv0.push_back(mk(1, 0, 32'h40, 1, 32'h40, 6'h00, 1, 0, 1, 32'h00, 3, 0));
        tv0.push_back(mk(1, 0, 32'h40, 1, 32'h40, 6'h00, 1, 0, 1, 32'h00, 4, 0));
        tv0.push_back(mk(1, 0, 32'h40, 1, 32'h40, 6'h00, 1, 0, 1, 32'h00, 5, 0));
        tv0.push_back(mk(1, 0, 32'h40, 1, 32'h40, 6'h00, 0, 0, 1, 32'h00, 6, 0));
        tv0.push_back(mk(1, 0, 32'h40, 1, 32'h40, 6'h00, 0, 0, 0, 32'h00, 7, 0));
        tv0.push_back(mk(1, 0, 32'h1040, 1, 32'h40, 6'h00, 0, 0, 0, 32'h00, 8, 0));
        tv0.push_back(mk(1, 0, 32'h40, 1, 32'h43, 6'h00, 0, 0, 0, 32'h00, 9, 0));
        tv0.push_back(mk(1, 0, 32'h43, 1, 32'h40, 6'h00, 1, 0, 0, 32'h00, 10, 0));
        // Speculative history shifts, including a not-taken prediction.
        tv0.push_back(mk(1, 1, 32'h80, 0, 32'h0, 6'h00, 0, 0, 1, 32'h01, 10, 0));
        tv0.push_back(mk(1, 1, 32'h80, 0, 32'h0, 6'h00, 0, 0, 1, 32'h03, 10, 0));
        tv0.push_back(mk(1, 1, 32'h80, 0, 32'h0, 6'h00, 0, 0, 1, 32'h07, 10, 0));
        tv0.push_back(mk(1, 1, 32'h5C, 0, 32'h0, 6'h00, 0, 0, 1, 32'h0E, 10, 0));
        // Mispredict repair, then repair winning over a same-cycle query.
        tv0.push_back(mk(1, 0, 32'h00, 1, 32'h0, 6'h15, 0, 1, 1, 32'h2A, 11, 1));
        tv0.push_back(mk(1, 1, 32'h14, 1, 32'h0, 6'h03, 0, 1, 0, 32'h06, 12, 2));
        // Paused with both enables high: nothing moves.
        for (int k = 0; k < 4; k++)
            tv0.push_back(mk(0, 1, 32'hD8, 1, 32'hC0, 6'h00, 0, 0, 1, 32'h06, 12, 2));
        tv0.push_back(mk(0, 1, 32'hD8, 1, 32'hC0, 6'h3F, 0, 1, 1, 32'h06, 12, 2));
        // Resume: exactly one update per cycle, then probe the slot.
        tv0.push_back(mk(1, 1, 32'hD8, 1, 32'hC0, 6'h00, 0, 0, 1, 32'h0D, 13, 2));
        tv0.push_back(mk(1, 1, 32'hD8, 1, 32'hC0, 6'h00, 0, 0, 1, 32'h1B, 14, 2));
        tv0.push_back(mk(1, 0, 32'hAC, 0, 32'h0,  6'h00, 0, 0, 0, 32'h1B, 14, 2));

        // Narrow instance: 1-bit counter saturation, 1-bit history, stat saturation at 3.
        tv1.push_back(mk(1, 0, 32'h4, 1, 32'h4, 6'h0, 0, 0, 0, 0, 1, 0));
        tv1.push_back(mk(1, 0, 32'h4, 1, 32'h4, 6'h0, 0, 1, 0, 0, 2, 1));
        tv1.push_back(mk(1, 0, 32'h0, 1, 32'h4, 6'h0, 1, 1, 1, 1, 3, 2));
        tv1.push_back(mk(1, 0, 32'hC, 1, 32'h8, 6'h1, 0, 1, 0, 0, 3, 3));
        tv1.push_back(mk(1, 1, 32'h0, 0, 32'h0, 6'h0, 0, 0, 1, 1, 3, 3));
        tv1.push_back(mk(1, 0, 32'h0, 1, 32'h0, 6'h0, 0, 1, 0, 0, 3, 3));

        // Asynchronous reset between edges: visible before any clock.
        b0.query_PC = 32'h44;
        #2 rst_n = 1'b0;
        #1;
        chk("rst0.result", 0, 32'(b0.result_out), 32'h1);
        chk("rst0.ghr",    0, 32'(b0.query_ghr_out), 32'h0);
        chk("rst0.total",  0, b0.stat_total_out, 32'h0);
        chk("rst0.miss",   0, b0.stat_miss_out, 32'h0);
        chk("rst1.result", 0, 32'(b1.result_out), 32'h1);
        chk("rst1.ghr",    0, 32'(b1.query_ghr_out), 32'h0);
        @(negedge clk_in);
        rst_n = 1'b1;

        foreach (tv0[i]) apply(0, "t0", i, tv0[i]);

        // Same-cycle query and update of one slot: old value until the edge.
        @(negedge clk_in);
        drive(0, mk(1, 0, 32'h2C, 1, 32'h40, 6'h00, 1, 0, 0, 0, 0, 0));
        #1;
        chk("nobypass.pre", 0, 32'(b0.result_out), 32'h0);
        @(posedge clk_in);
        #1;
        chk("nobypass.post", 0, 32'(b0.result_out), 32'h1);
        chk("nobypass.total", 0, b0.stat_total_out, 32'd15);

        // Reset mid-operation with an update pending and rdy low: update discarded.
        @(negedge clk_in);
        drive(0, mk(0, 0, 32'h44, 1, 32'h44, 6'h00, 0, 1, 0, 0, 0, 0));
        #1 rst_n = 1'b0;
        #1;
        chk("midrst.result", 0, 32'(b0.result_out), 32'h1);
        chk("midrst.ghr",    0, 32'(b0.query_ghr_out), 32'h0);
        chk("midrst.total",  0, b0.stat_total_out, 32'h0);
        chk("midrst.miss",   0, b0.stat_miss_out, 32'h0);
        rdy0 = 1'b1;
        @(posedge clk_in);
        @(negedge clk_in);
        b0.update_en = 1'b0;
        rst_n = 1'b1;
        #1;
        chk("postrst.result", 0, 32'(b0.result_out), 32'h1);
        chk("postrst.total",  0, b0.stat_total_out, 32'h0);
        apply(0, "first_upd", 0, mk(1, 0, 32'h44, 1, 32'h44, 6'h00, 0, 0, 0, 32'h0, 1, 0));

        foreach (tv1[i]) apply(1, "t1", i, tv1[i]);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
        $finish;
    end

    // Absolute time bound in case the stimulus stalls.
    initial begin
        #100000;
        $display("FAIL timeout: got no finish expected finish before 100000ns");
        $fatal(1);
    end
endmodule
